// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and data access.
// Optional fetch anti-starvation override is enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int MEM_AW     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              stall_f,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              stall_m,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_force_f;
    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    // Byte-offset and out-of-range address bits are deliberately ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                                  dm_addr[31:MEM_AW+2], dm_addr[1:0]};

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    // Saturating count of consecutive cycles fetch was denied; retained across dropped requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (stall_f && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_f = if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign w_force_f = 1'b0;
`endif

    assign w_dm_gnt = dm_req & ~w_force_f;
    assign w_if_gnt = if_req & ~w_dm_gnt;

    assign stall_f = if_req & ~w_if_gnt;
    assign stall_m = dm_req & ~w_dm_gnt;

    assign mem_en = reset & (w_if_gnt | w_dm_gnt);
    assign mem_we = w_dm_gnt & dm_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_dm_gnt) begin
            mem_addr  = dm_addr[MEM_AW+1:2];
            mem_wdata = dm_wdata;
        end else if (w_if_gnt) begin
            mem_addr  = if_addr[MEM_AW+1:2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The state names the owner of the read whose data arrives on mem_rdata this cycle.
    always_comb begin
        w_state_next = IDLE;
        if_valid     = 1'b0;
        dm_valid     = 1'b0;
        if (w_if_gnt) begin
            w_state_next = RD_IF;
        end else if (w_dm_gnt && !dm_we) begin
            w_state_next = RD_DM;
        end
        case (r_state)
            RD_IF:   if_valid = 1'b1;
            RD_DM:   dm_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (r_state == RD_IF) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_state == RD_DM) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: bench-side RAM plus a golden-memory reference model.
// Expectations adapt to whether ARB_FAIR_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MEM_AW     = 10;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << MEM_AW;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              stall_f;
    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_valid;
    logic              stall_m;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_port_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .stall_f(stall_f),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_m(stall_m),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM with one-cycle read latency, plus a preload port.
    logic [31:0]       ram [DEPTH];
    logic [31:0]       ram_q;
    logic              ld_en;
    logic [MEM_AW-1:0] ld_addr;
    logic [31:0]       ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model: golden memory contents, the read in flight and the captured data.
    logic [31:0] golden [DEPTH];
    int          m_starve;
    int          m_inflight;      // 0 none, 1 fetch, 2 data
    logic [31:0] m_inflight_data;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;
    logic        e_if_win;
    logic        e_dm_win;
    logic        obs_stall_f;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_starve        = 0;
        m_inflight      = 0;
        m_inflight_data = '0;
        m_if_rdata      = '0;
        m_dm_rdata      = '0;
    endtask

    task automatic model_grant();
        logic force_f;
        force_f  = FAIR && if_req && (m_starve == STARVE_MAX);
        e_dm_win = dm_req && !force_f;
        e_if_win = if_req && !e_dm_win;
    endtask

    // One clock: check every output mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [MEM_AW-1:0] ea;
        logic [31:0]       ew;
        if (!reset) model_clear();
        model_grant();
        @(negedge clk);
        ea = e_dm_win ? dm_addr[MEM_AW+1:2] : (e_if_win ? if_addr[MEM_AW+1:2] : '0);
        ew = e_dm_win ? dm_wdata : 32'h0;
        obs_stall_f = stall_f;
        check("mem_en",    32'(mem_en),    32'(reset && (e_if_win || e_dm_win)));
        check("mem_we",    32'(mem_we),    32'(e_dm_win && dm_we));
        check("mem_addr",  32'(mem_addr),  32'(ea));
        check("mem_wdata", mem_wdata,      ew);
        check("stall_f",   32'(stall_f),   32'(if_req && !e_if_win));
        check("stall_m",   32'(stall_m),   32'(dm_req && !e_dm_win));
        check("if_valid",  32'(if_valid),  32'(m_inflight == 1));
        check("dm_valid",  32'(dm_valid),  32'(m_inflight == 2));
        check("if_rdata",  if_rdata,       m_if_rdata);
        check("dm_rdata",  dm_rdata,       m_dm_rdata);
        @(posedge clk);
        if (reset) begin
            if (m_inflight == 1)      m_if_rdata = m_inflight_data;
            else if (m_inflight == 2) m_dm_rdata = m_inflight_data;
            if (e_if_win) begin
                m_inflight      = 1;
                m_inflight_data = golden[if_addr[MEM_AW+1:2]];
            end else if (e_dm_win && !dm_we) begin
                m_inflight      = 2;
                m_inflight_data = golden[dm_addr[MEM_AW+1:2]];
            end else begin
                m_inflight = 0;
            end
            if (e_dm_win && dm_we) golden[dm_addr[MEM_AW+1:2]] = dm_wdata;
            if (e_if_win)                               m_starve = 0;
            else if (if_req && m_starve < STARVE_MAX)   m_starve++;
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic set_if(input logic req, input logic [31:0] addr);
        if_req  = req;
        if_addr = addr;
    endtask

    task automatic set_dm(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        dm_req   = req;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
    endtask

    initial begin
        int          first_gnt;
        int          n_gnt;
        logic [31:0] v;
        checks   = 0;
        failures = 0;
        model_clear();
        reset = 1'b0;
        set_if(1'b1, 32'h10);
        set_dm(1'b0, 1'b0, 32'h0, 32'h0);
        ld_en   = 1'b1;
        ld_addr = '0;
        ld_data = '0;

        // Preload RAM and golden memory while reset is held with a fetch pending.
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 4) ? 32'hE3A00001 : $urandom;
            ld_addr   = MEM_AW'(i);
            ld_data   = v;
            golden[i] = v;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        cycle();
        cycle();

        // Release: fetch of 0x10 granted in the same cycle, data back two cycles later.
        reset = 1'b1;
        cycle();
        set_if(1'b0, 32'h0);
        cycle();
        cycle();
        check("fetch_word4", if_rdata, 32'hE3A00001);

        // Simultaneous requests: data first, fetch retried next cycle.
        set_if(1'b1, 32'h40);
        set_dm(1'b1, 1'b0, 32'h20, 32'h0);
        cycle();
        set_dm(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        set_if(1'b0, 32'h0);
        cycle();
        cycle();

        // Write then read back the same word.
        set_dm(1'b1, 1'b1, 32'h30, 32'hDEADBEEF);
        cycle();
        set_dm(1'b1, 1'b0, 32'h30, 32'h0);
        cycle();
        set_dm(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        check("dm_readback", dm_rdata, 32'hDEADBEEF);

        // Data held busy for 10 cycles while fetch waits.
        first_gnt = 0;
        n_gnt     = 0;
        set_if(1'b1, 32'h44);
        set_dm(1'b1, 1'b0, 32'h48, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (!obs_stall_f) begin
                n_gnt++;
                if (first_gnt == 0) first_gnt = c;
            end
        end
        check("starve_first_gnt", 32'(first_gnt), FAIR ? 32'd5 : 32'd0);
        check("starve_n_gnt",     32'(n_gnt),     FAIR ? 32'd2 : 32'd0);
        set_if(1'b0, 32'h0);
        set_dm(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();

        // Reset pulsed while a fetch read is in flight.
        set_if(1'b1, 32'h10);
        cycle();
        set_if(1'b0, 32'h0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_if_rdata", if_rdata, 32'h0);

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) != 0);
            set_if(1'($urandom_range(0, 1)), $urandom);
            set_dm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            cycle();
        end
        reset = 1'b1;
        set_if(1'b0, 32'h0);
        set_dm(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
